// File: rtl/mem_ctrl_if.sv
// Bundle of every non-clock signal of the memory controller.
//
// The controller serves two requesters over one byte-wide RAM.
//
// Instruction-fetch port:
//   if_req    requester -> ctrl  level request, held until if_done
//   if_addr   requester -> ctrl  fetch byte address
//   if_flush  requester -> ctrl  abort an in-flight fetch (branch redirect)
//   if_done   ctrl -> requester  one-cycle pulse, if_inst valid
//   if_inst   ctrl -> requester  fetched word, little-endian
//
// Load/store port:
//   mem_req   requester -> ctrl  level request, held until mem_done
//   mem_wr    requester -> ctrl  1 = store, 0 = load
//   mem_len   requester -> ctrl  0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   mem_addr  requester -> ctrl  load/store byte address
//   mem_wdata requester -> ctrl  store data, byte 0 written first
//   mem_done  ctrl -> requester  one-cycle pulse, access complete
//   mem_rdata ctrl -> requester  load data, zero-extended
//
// RAM side:
//   ram_a     ctrl -> RAM        byte address
//   ram_dout  ctrl -> RAM        write data
//   ram_wr    ctrl -> RAM        write strobe
//   ram_din   RAM -> ctrl        read data, one edge after ram_a is sampled
//
// The slave modport is the controller's view; the master modport is the
// view of the environment (both requesters plus the RAM).
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_inst,
    output mem_done, mem_rdata,
    output ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_inst,
    input  mem_done, mem_rdata,
    input  ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by an instruction-fetch port and a
// load/store port. Accesses are moved one byte per cycle over an 8-bit RAM
// whose read data appears one edge after the address is sampled.
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset; clears the FSM and every output
//   bus  mem_ctrl_if.slave -- fetch port, load/store port and RAM side
//
// Behaviour in short:
//   - The load/store port has fixed priority over fetches when both are
//     pending in IDLE. A running transaction is never preempted.
//   - Reads of N bytes finish N+1 edges after acceptance, writes N edges
//     after acceptance; the FSM then spends exactly one cycle in DONE with
//     the matching done pulse high, and requests are not sampled there.
//   - if_flush aborts a fetch in IF_RD and blocks fetch acceptance in IDLE.
//   - All outputs are registers written only by the FSM block.
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [2:0]  nbytes;
  logic [2:0]  step;
  logic [31:0] wdata;
  logic [23:0] rbuf;

  // edge_k numbers the edge about to happen, counting the acceptance edge
  // as 0; step holds edge_k - 1 while a transfer is running.
  logic [2:0]  edge_k;
  logic [31:0] next_a;

  assign edge_k = step + 3'd1;
  // Plain 32-bit addition, so the byte address wraps from 0xFFFFFFFF to 0.
  assign next_a = base + {29'd0, edge_k};

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Only the first three bytes are buffered: the final byte of a read is
  // taken straight from ram_din on the completion edge.
  function automatic logic [23:0] put_byte(input logic [23:0] buf_in,
                                           input logic [2:0]  idx,
                                           input logic [7:0]  b);
    logic [23:0] r;
    r = buf_in;
    case (idx)
      3'd0:    r[7:0]   = b;
      3'd1:    r[15:8]  = b;
      default: r[23:16] = b;
    endcase
    return r;
  endfunction

  // Loads shorter than a word leave the upper bytes at zero.
  function automatic logic [31:0] load_word(input logic [2:0]  n,
                                            input logic [23:0] buf_in,
                                            input logic [7:0]  last);
    logic [31:0] w;
    case (n)
      3'd1:    w = {24'd0, last};
      3'd2:    w = {16'd0, last, buf_in[7:0]};
      default: w = {last, buf_in};
    endcase
    return w;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                           input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = w[7:0];
      3'd1:    b = w[15:8];
      3'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      base          <= 32'd0;
      nbytes        <= 3'd0;
      step          <= 3'd0;
      wdata         <= 32'd0;
      rbuf          <= 24'd0;
      bus.if_done   <= 1'b0;
      bus.if_inst   <= 32'd0;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= 32'd0;
      bus.ram_a     <= 32'd0;
      bus.ram_dout  <= 8'd0;
      bus.ram_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step <= 3'd0;
          if (bus.mem_req) begin
            // Load/store wins; a simultaneous if_flush has no say here.
            base      <= bus.mem_addr;
            nbytes    <= len_bytes(bus.mem_len);
            wdata     <= bus.mem_wdata;
            bus.ram_a <= bus.mem_addr;
            if (bus.mem_wr) begin
              bus.ram_dout <= bus.mem_wdata[7:0];
              bus.ram_wr   <= 1'b1;
              state        <= MEM_WR;
            end else begin
              state <= MEM_RD;
            end
          end else if (bus.if_req && !bus.if_flush) begin
            base      <= bus.if_addr;
            nbytes    <= 3'd4;
            bus.ram_a <= bus.if_addr;
            state     <= IF_RD;
          end
        end

        IF_RD, MEM_RD: begin
          if (state == IF_RD && bus.if_flush) begin
            // Abandon the fetch; partial bytes are simply never published.
            state <= IDLE;
          end else begin
            step <= edge_k;
            if (edge_k < nbytes) begin
              bus.ram_a <= next_a;
            end
            // Byte j shows up on ram_din at edge j+2.
            if (edge_k >= 3'd2 && edge_k <= nbytes) begin
              rbuf <= put_byte(rbuf, edge_k - 3'd2, bus.ram_din);
            end
            if (edge_k == nbytes + 3'd1) begin
              state <= DONE;
              if (state == IF_RD) begin
                bus.if_done <= 1'b1;
                bus.if_inst <= {bus.ram_din, rbuf};
              end else begin
                bus.mem_done  <= 1'b1;
                bus.mem_rdata <= load_word(nbytes, rbuf, bus.ram_din);
              end
            end
          end
        end

        MEM_WR: begin
          if (edge_k < nbytes) begin
            step         <= edge_k;
            bus.ram_a    <= next_a;
            bus.ram_dout <= pick_byte(wdata, edge_k);
          end else begin
            // Stores carry no read data, so mem_rdata keeps its last load.
            bus.ram_wr   <= 1'b0;
            bus.mem_done <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          bus.if_done  <= 1'b0;
          bus.mem_done <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios with literal
// expectations followed by two random requesters running concurrently.
// A transaction-level model predicts every output each cycle from the
// byte counts and latencies of each access type.
module tb_mem_ctrl;

  logic clk;
  logic rst;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // RAM contents alias on the low 12 address bits.
  logic [7:0]  ram    [4096];
  logic [7:0]  shadow [4096];
  logic        fill_en;
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  function automatic logic [7:0] fill_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Byte-wide synchronous RAM; data for the address sampled on one edge
  // is visible after that edge.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) ram[i] <= fill_byte(i);
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.ram_wr) begin
      ram[bus.ram_a[11:0]] <= bus.ram_dout;
    end
    bus.ram_din <= ram[bus.ram_a[11:0]];
  end

  // ---------------------------------------------------------------- model
  logic        chk_en = 1'b0;
  logic        exp_if_done, exp_mem_done, exp_ram_wr;
  logic [31:0] exp_if_inst, exp_mem_rdata, exp_ram_a;
  logic [7:0]  exp_ram_dout;

  function automatic logic [31:0] gather(input logic [31:0] a, input int n);
    logic [31:0] v;
    logic [31:0] ai;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v[8*i +: 8] = shadow[ai[11:0]];
    end
    return v;
  endfunction

  // One accepted transaction is tracked by its kind, base, byte count and
  // the number of edges since acceptance.
  initial begin
    bit          busy;
    bit          is_fetch;
    bit          is_wr;
    int          n;
    int          k;
    int          done_k;
    logic [31:0] base;
    logic [31:0] wd;
    logic [31:0] a;
    busy = 0; is_fetch = 0; is_wr = 0; n = 0; k = 0; base = 0; wd = 0;
    forever begin
      @(posedge clk);
      if (fill_en) for (int i = 0; i < 4096; i++) shadow[i] = fill_byte(i);
      else if (pl_en) shadow[pl_addr] = pl_data;
      if (rst) begin
        chk_en        = 1'b1;
        busy          = 0;
        exp_if_done   = 1'b0;
        exp_mem_done  = 1'b0;
        exp_ram_wr    = 1'b0;
        exp_if_inst   = 32'd0;
        exp_mem_rdata = 32'd0;
        exp_ram_a     = 32'd0;
        exp_ram_dout  = 8'd0;
      end else if (!busy) begin
        if (bus.mem_req) begin
          busy = 1; is_fetch = 0; is_wr = bus.mem_wr;
          n = (bus.mem_len == 2'd0) ? 1 : (bus.mem_len == 2'd1) ? 2 : 4;
          base = bus.mem_addr; wd = bus.mem_wdata; k = 0;
          exp_ram_a = base;
          if (is_wr) begin
            exp_ram_wr   = 1'b1;
            exp_ram_dout = wd[7:0];
            shadow[base[11:0]] = wd[7:0];
          end
        end else if (bus.if_req && !bus.if_flush) begin
          busy = 1; is_fetch = 1; is_wr = 0; n = 4;
          base = bus.if_addr; k = 0;
          exp_ram_a = base;
        end
      end else begin
        k++;
        done_k = is_wr ? n : n + 1;
        if (k == done_k + 1) begin
          busy = 0;
          exp_if_done  = 1'b0;
          exp_mem_done = 1'b0;
        end else if (is_fetch && bus.if_flush) begin
          busy = 0;
        end else begin
          if (k <= n - 1) begin
            a = base + 32'(k);
            exp_ram_a = a;
            if (is_wr) begin
              exp_ram_dout = wd[8*k +: 8];
              shadow[a[11:0]] = wd[8*k +: 8];
            end
          end
          if (k == done_k) begin
            exp_ram_wr = 1'b0;
            if (is_fetch) begin
              exp_if_done = 1'b1;
              exp_if_inst = gather(base, 4);
            end else begin
              exp_mem_done = 1'b1;
              if (!is_wr) exp_mem_rdata = gather(base, n);
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- checking
  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check_val("if_done",   32'(bus.if_done),   32'(exp_if_done));
    check_val("if_inst",   bus.if_inst,        exp_if_inst);
    check_val("mem_done",  32'(bus.mem_done),  32'(exp_mem_done));
    check_val("mem_rdata", bus.mem_rdata,      exp_mem_rdata);
    check_val("ram_a",     bus.ram_a,          exp_ram_a);
    check_val("ram_dout",  32'(bus.ram_dout),  32'(exp_ram_dout));
    check_val("ram_wr",    32'(bus.ram_wr),    32'(exp_ram_wr));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check_output();
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic set_mem(input logic wr, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] d);
    bus.mem_req = 1'b1; bus.mem_wr = wr; bus.mem_len = len;
    bus.mem_addr = a; bus.mem_wdata = d;
  endtask

  task automatic fetch_requester(input int count);
    bit got;
    int flush_at;
    bit do_flush;
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.if_addr = $urandom;
      bus.if_req  = 1'b1;
      do_flush = ($urandom_range(0, 3) == 0);
      flush_at = $urandom_range(0, 12);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        bus.if_flush = 1'b0;
        if (bus.if_done) got = 1;
        else if (do_flush && c == flush_at) bus.if_flush = 1'b1;
      end
      bus.if_flush = 1'b0;
      bus.if_req   = 1'b0;
      check_val("fetch_completes", 32'(got), 32'd1);
    end
  endtask

  task automatic mem_requester(input int count);
    bit got;
    logic [31:0] a;
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : $urandom;
      set_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (bus.mem_done) got = 1;
      end
      bus.mem_req = 1'b0;
      check_val("mem_completes", 32'(got), 32'd1);
    end
  endtask

  task automatic apply_stimulus();
    // Reset state.
    check_val("reset_if_inst", bus.if_inst, 32'd0);
    check_val("reset_ram_wr", 32'(bus.ram_wr), 32'd0);
    check_val("reset_mem_rdata", bus.mem_rdata, 32'd0);

    preload(12'h100, 8'h13); preload(12'h101, 8'h00);
    preload(12'h102, 8'h50); preload(12'h103, 8'h00);
    preload(12'h030, 8'h8F);
    preload(12'h300, 8'h11); preload(12'h301, 8'h22);
    preload(12'h302, 8'h33); preload(12'h303, 8'h44);
    preload(12'h200, 8'hAA); preload(12'h201, 8'hBB);
    preload(12'h202, 8'hCC); preload(12'h203, 8'hDD);
    preload(12'hFFE, 8'h01); preload(12'hFFF, 8'h02);

    // Plain fetch: four addresses, done after edge 5.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e <= 3) check_val("fetch_ram_a", bus.ram_a, 32'h100 + 32'(e));
      check_val("fetch_done", 32'(bus.if_done), 32'(e == 5));
    end
    check_val("fetch_inst", bus.if_inst, 32'h0050_0013);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Two-byte store.
    set_mem(1'b1, 2'd1, 32'h2000, 32'hDEAD_BEEF);
    for (int e = 0; e <= 2; e++) begin
      @(negedge clk);
      check_val("store_wr", 32'(bus.ram_wr), 32'(e < 2));
      check_val("store_done", 32'(bus.mem_done), 32'(e == 2));
      if (e == 1) check_val("store_a1", bus.ram_a, 32'h2001);
      if (e == 1) check_val("store_d1", 32'(bus.ram_dout), 32'hBE);
    end
    bus.mem_req = 1'b0;
    @(negedge clk);
    check_val("store_ram0", 32'(ram[12'h000]), 32'hEF);
    check_val("store_ram1", 32'(ram[12'h001]), 32'hBE);

    // Contention: load served first, fetch on the first IDLE edge after DONE.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    set_mem(1'b0, 2'd0, 32'h30, 32'd0);
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      if (e == 0) check_val("cont_a_mem", bus.ram_a, 32'h30);
      if (e == 2) check_val("cont_rdata", bus.mem_rdata, 32'h0000_008F);
      if (e == 2) bus.mem_req = 1'b0;
      if (e == 3) check_val("cont_a_hold", bus.ram_a, 32'h30);
      if (e == 4) check_val("cont_a_fetch", bus.ram_a, 32'h300);
      check_val("cont_if_done", 32'(bus.if_done), 32'(e == 9));
    end
    check_val("cont_inst", bus.if_inst, 32'h4433_2211);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Flush in IF_RD, then a fresh fetch at 0x200.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      if (e == 2) begin bus.if_flush = 1'b1; bus.if_req = 1'b0; end
      if (e == 3) begin
        check_val("flush_a_hold", bus.ram_a, 32'h102);
        bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h200;
      end
      if (e == 4) check_val("flush_a_new", bus.ram_a, 32'h200);
      check_val("flush_if_done", 32'(bus.if_done), 32'(e == 9));
    end
    check_val("flush_inst", bus.if_inst, 32'hDDCC_BBAA);
    bus.if_req = 1'b0;
    @(negedge clk);

    // if_flush in IDLE blocks a fetch for that edge only.
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.if_flush = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      bus.if_flush = 1'b0;
      if (e == 0) check_val("idle_flush_block", bus.ram_a, 32'h203);
      if (e == 1) check_val("idle_flush_accept", bus.ram_a, 32'h100);
      check_val("idle_flush_done", 32'(bus.if_done), 32'(e == 6));
    end
    bus.if_req = 1'b0;
    @(negedge clk);

    // if_flush together with mem_req: the load still goes.
    bus.if_flush = 1'b1;
    set_mem(1'b0, 2'd0, 32'h30, 32'd0);
    @(negedge clk);
    bus.if_flush = 1'b0;
    check_val("flush_mem_accept", bus.ram_a, 32'h30);
    repeat (2) @(negedge clk);
    check_val("flush_mem_done", 32'(bus.mem_done), 32'd1);
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Four-byte load across the top of the address space.
    set_mem(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0);
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e <= 3) check_val("wrap_ram_a", bus.ram_a, 32'hFFFF_FFFE + 32'(e));
      check_val("wrap_done", 32'(bus.mem_done), 32'(e == 5));
    end
    check_val("wrap_rdata", bus.mem_rdata, 32'hBEEF_0201);
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a store.
    set_mem(1'b1, 2'd2, 32'h400, 32'h1234_5678);
    @(negedge clk);
    check_val("rst_wr_before", 32'(bus.ram_wr), 32'd1);
    rst = 1'b1; bus.mem_req = 1'b0;
    @(negedge clk);
    check_val("rst_wr_after", 32'(bus.ram_wr), 32'd0);
    check_val("rst_ram_a", bus.ram_a, 32'd0);
    check_val("rst_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      check_val("rst_no_done", 32'(bus.mem_done), 32'd0);
    end

    // Random traffic from both ports at once.
    fork
      fetch_requester(60);
      mem_requester(60);
    join
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fill_en = 1'b1; pl_en = 1'b0; pl_addr = 12'd0; pl_data = 8'd0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = 2'd0;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    repeat (2) @(negedge clk);
    fill_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released, starting stimulus");
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_flush  in  1  abort an in-flight fetch (branch redirect)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, level, held until mem_done
- mem_wr  in  1  1 = store, 0 = load
- mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data, byte 0 written first
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load data, zero-extended
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write data
- ram_wr  out  1  RAM write strobe
- ram_din  in  8  RAM read data, valid one edge after ram_a is sampled
REQ-002 All outputs SHALL be registered.

Function
REQ-003 FSM states SHALL be IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-004 In IDLE with mem_req=1, the block SHALL accept the mem request; otherwise, with if_req=1, it SHALL accept the fetch (fixed priority, mem over if).
REQ-005 On acceptance (edge E0), the block SHALL latch the address, length and write data, and SHALL drive ram_a = base address.
REQ-006 There SHALL be no preemption: a request arriving mid-transaction waits until the FSM returns to IDLE.
REQ-007 Read, N bytes (fetch N=4):
- edge Ek (1 <= k <= N-1): ram_a = base+k
- edge E(k+2): capture ram_din into byte k
- edge E(N+1): enter DONE and pulse done; 4-byte read latency = 5 edges.
REQ-008 Write, N bytes:
- edge Ek (0 <= k <= N-1): ram_a = base+k, ram_dout = wdata byte k, ram_wr = 1
- edge EN: ram_wr = 0, enter DONE, pulse mem_done.
REQ-009 DONE SHALL last exactly one cycle, during which the matching done output is 1, then return to IDLE; requests SHALL NOT be sampled in DONE.
REQ-010 Requesters SHALL drop req at the edge ending DONE; a req still high in IDLE SHALL be treated as a new request.
REQ-011 Address increment SHALL be modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
REQ-012 For mem loads with N < 4, unread upper bytes of mem_rdata SHALL be 0.
REQ-013 if_inst and mem_rdata SHALL hold their last value until the next completion of their own port.
REQ-014 if_flush in IF_RD SHALL return the FSM to IDLE at the next edge with no if_done.
REQ-015 if_flush in IDLE SHALL block acceptance of if_req on that edge; if_flush SHALL be ignored in MEM_RD, MEM_WR and DONE.
REQ-016 When if_flush and mem_req are both 1 in IDLE, the mem request SHALL be accepted.
REQ-017 ram_wr SHALL be 1 only in MEM_WR.

Reset
REQ-018 When rst=1 at an edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (ram_wr=0, done pulses=0, data=0), including mid-transaction.
REQ-019 Partial transfers SHALL be discarded on reset with no done pulse.

Verification
REQ-020 Fetch: if_addr=0x100, RAM[0x100..0x103]=13,00,50,00 -> ram_a sequence 0x100..0x103; if_done at edge E5; if_inst=0x00500013.
REQ-021 Store: mem_wr=1, len=1, addr=0x2000, wdata=0xDEADBEEF -> ram_wr=1 for 2 cycles, bytes EF,BE at 0x2000/0x2001; mem_done at E2.
REQ-022 Contention: if_req and mem_req both rise in IDLE (load, len=0, addr=0x30, RAM=0x8F) -> mem served first, mem_rdata=0x0000008F; fetch accepted the first IDLE edge after DONE.
REQ-023 Flush: during IF_RD at E2, assert if_flush -> no if_done, IDLE at E3; a new if_req at 0x200 then completes normally.
REQ-024 Wrap and reset: 4-byte load at 0xFFFFFFFE -> ram_a = FFFFFFFE, FFFFFFFF, 0, 1. Separately, rst during MEM_WR at E1 -> ram_wr=0 next cycle, no mem_done.
